// File: rtl/controle_operacoes_matriz_pkg.sv
// Shared definitions for the 5x5 matrix operation sequencer: op codes, matrix ids,
// dimension and FSM state encoding.
package pacote_matrizes;

  localparam int DIM = 5;

  typedef enum logic [1:0] {
    OP_SOMA = 2'b00,
    OP_SUB  = 2'b01,
    OP_MUL  = 2'b10,
    OP_INV  = 2'b11
  } op_t;

  localparam logic [1:0] ID_A = 2'b00;
  localparam logic [1:0] ID_B = 2'b01;
  localparam logic [1:0] ID_C = 2'b10;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD_A,
    ST_RD_B,
    ST_CALC,
    ST_WR,
    ST_FIM
  } estado_t;

endpackage

// File: rtl/controle_operacoes_matriz_mac.sv
// Combinational add/sub/multiply-accumulate with overflow detection and result narrowing.
// Define SATURACAO_EN to clamp out-of-range results; otherwise the low WIDTH bits are kept.
module unidade_mac
  import pacote_matrizes::*;
#(
  parameter int WIDTH = 16,
  parameter int ACC_W = 2*WIDTH+3
)(
  input  op_t                     i_op,
  input  logic signed [WIDTH-1:0] i_a,
  input  logic signed [WIDTH-1:0] i_b,
  input  logic signed [ACC_W-1:0] i_acc,
  input  logic                    i_acc_clr,
  output logic signed [ACC_W-1:0] o_acc,
  output logic [WIDTH-1:0]        o_res,
  output logic                    o_ovf
);

  logic signed [WIDTH:0]       w_soma;
  logic signed [2*WIDTH-1:0]   w_prod;
  logic signed [ACC_W-1:0]     w_full;
  logic [ACC_W-WIDTH:0]        w_topo;

  always_comb begin
    if (i_op == OP_SUB)
      w_soma = {i_a[WIDTH-1], i_a} - {i_b[WIDTH-1], i_b};
    else
      w_soma = {i_a[WIDTH-1], i_a} + {i_b[WIDTH-1], i_b};

    w_prod = (2*WIDTH)'(i_a) * (2*WIDTH)'(i_b);
    o_acc  = (i_acc_clr ? '0 : i_acc)
           + {{(ACC_W-2*WIDTH){w_prod[2*WIDTH-1]}}, w_prod};

    w_full = (i_op == OP_MUL) ? o_acc
                              : {{(ACC_W-WIDTH-1){w_soma[WIDTH]}}, w_soma};

    // In range only when every bit above the narrowed sign bit matches it
    w_topo = w_full[ACC_W-1:WIDTH-1];
    o_ovf  = ~((&w_topo) | ~(|w_topo));

`ifdef SATURACAO_EN
    if (o_ovf)
      o_res = w_full[ACC_W-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    else
      o_res = w_full[WIDTH-1:0];
`else
    o_res = w_full[WIDTH-1:0];
`endif
  end

endmodule

// File: rtl/controle_operacoes_matriz.sv
// Sequencer computing C = A op B (add, sub, product) over the 5x5 matrix memory port.
// Build option SATURACAO_EN selects saturating instead of wrapping result writes.
module controle_operacoes_matriz
  import pacote_matrizes::*;
#(
  parameter int DIM   = pacote_matrizes::DIM,
  parameter int WIDTH = 16
)(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic             erro,
  output logic             overflow,
  output logic             mem_we,
  output logic             mem_re,
  output logic [1:0]       mem_id,
  output logic [2:0]       mem_linha,
  output logic [2:0]       mem_coluna,
  output logic [WIDTH-1:0] mem_dado_w,
  input  logic [WIDTH-1:0] mem_dado_r
);

  localparam int         ACC_W = 2*WIDTH+3;
  localparam logic [2:0] ULT   = 3'(DIM-1);

  estado_t r_estado, w_estado_nxt;
  op_t     r_op, w_op_nxt;
  logic [2:0] r_i, r_j, r_k;
  logic [2:0] w_i_nxt, w_j_nxt, w_k_nxt;
  logic signed [WIDTH-1:0] r_a;
  logic signed [ACC_W-1:0] r_acc, w_acc_nxt;
  logic [WIDTH-1:0] w_res;
  logic w_ovf, w_erro_nxt, w_aceita;

  logic             w_re_nxt, w_we_nxt;
  logic [1:0]       w_id_nxt;
  logic [2:0]       w_lin_nxt, w_col_nxt;
  logic [WIDTH-1:0] w_dado_nxt;

  unidade_mac #(
    .WIDTH (WIDTH),
    .ACC_W (ACC_W)
  ) u_mac (
    .i_op      (r_op),
    .i_a       (r_a),
    .i_b       (mem_dado_r),
    .i_acc     (r_acc),
    .i_acc_clr (r_k == 3'd0),
    .o_acc     (w_acc_nxt),
    .o_res     (w_res),
    .o_ovf     (w_ovf)
  );

  always_comb begin
    w_estado_nxt = r_estado;
    w_op_nxt     = r_op;
    w_i_nxt      = r_i;
    w_j_nxt      = r_j;
    w_k_nxt      = r_k;
    w_erro_nxt   = 1'b0;
    w_aceita     = 1'b0;
    unique case (r_estado)
      ST_IDLE: begin
        if (start) begin
          if (op_t'(op) == OP_INV) begin
            w_estado_nxt = ST_FIM;
            w_erro_nxt   = 1'b1;
          end else begin
            w_aceita     = 1'b1;
            w_op_nxt     = op_t'(op);
            w_i_nxt      = '0;
            w_j_nxt      = '0;
            w_k_nxt      = '0;
            w_estado_nxt = ST_RD_A;
          end
        end
      end
      ST_RD_A: w_estado_nxt = ST_RD_B;
      ST_RD_B: w_estado_nxt = ST_CALC;
      ST_CALC: begin
        if (r_op == OP_MUL && r_k != ULT) begin
          w_k_nxt      = r_k + 3'd1;
          w_estado_nxt = ST_RD_A;
        end else begin
          w_estado_nxt = ST_WR;
        end
      end
      ST_WR: begin
        w_k_nxt      = '0;
        w_estado_nxt = ST_RD_A;
        if (r_j == ULT) begin
          w_j_nxt = '0;
          if (r_i == ULT) begin
            w_i_nxt      = '0;
            w_estado_nxt = ST_FIM;
          end else begin
            w_i_nxt = r_i + 3'd1;
          end
        end else begin
          w_j_nxt = r_j + 3'd1;
        end
      end
      ST_FIM:  w_estado_nxt = ST_IDLE;
      default: w_estado_nxt = ST_IDLE;
    endcase
  end

  // Memory port values are decoded from the next state so they are registered
  // and valid during the cycle of the state that owns them.
  always_comb begin
    w_re_nxt   = 1'b0;
    w_we_nxt   = 1'b0;
    w_id_nxt   = '0;
    w_lin_nxt  = '0;
    w_col_nxt  = '0;
    w_dado_nxt = '0;
    case (w_estado_nxt)
      ST_RD_A: begin
        w_re_nxt  = 1'b1;
        w_id_nxt  = ID_A;
        w_lin_nxt = w_i_nxt;
        w_col_nxt = (w_op_nxt == OP_MUL) ? w_k_nxt : w_j_nxt;
      end
      ST_RD_B: begin
        w_re_nxt  = 1'b1;
        w_id_nxt  = ID_B;
        w_lin_nxt = (w_op_nxt == OP_MUL) ? w_k_nxt : w_i_nxt;
        w_col_nxt = w_j_nxt;
      end
      ST_WR: begin
        w_we_nxt   = 1'b1;
        w_id_nxt   = ID_C;
        w_lin_nxt  = w_i_nxt;
        w_col_nxt  = w_j_nxt;
        w_dado_nxt = w_res;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado   <= ST_IDLE;
      r_op       <= OP_SOMA;
      r_i        <= '0;
      r_j        <= '0;
      r_k        <= '0;
      r_a        <= '0;
      r_acc      <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      erro       <= 1'b0;
      overflow   <= 1'b0;
      mem_we     <= 1'b0;
      mem_re     <= 1'b0;
      mem_id     <= '0;
      mem_linha  <= '0;
      mem_coluna <= '0;
      mem_dado_w <= '0;
    end else begin
      r_estado <= w_estado_nxt;
      r_op     <= w_op_nxt;
      r_i      <= w_i_nxt;
      r_j      <= w_j_nxt;
      r_k      <= w_k_nxt;
      if (r_estado == ST_RD_B)
        r_a <= mem_dado_r;
      if (r_estado == ST_CALC && r_op == OP_MUL)
        r_acc <= w_acc_nxt;
      busy <= (w_estado_nxt == ST_RD_A) || (w_estado_nxt == ST_RD_B) ||
              (w_estado_nxt == ST_CALC) || (w_estado_nxt == ST_WR);
      done <= (w_estado_nxt == ST_FIM);
      erro <= w_erro_nxt;
      if (w_aceita)
        overflow <= 1'b0;
      else if (w_estado_nxt == ST_WR && w_ovf)
        overflow <= 1'b1;
      mem_we     <= w_we_nxt;
      mem_re     <= w_re_nxt;
      mem_id     <= w_id_nxt;
      mem_linha  <= w_lin_nxt;
      mem_coluna <= w_col_nxt;
      mem_dado_w <= w_dado_nxt;
    end
  end

endmodule

// File: doc/controle_operacoes_matriz.md
# controle_operacoes_matriz

Sequencer that computes C = A op B over the three 5x5 matrices held in `memoria_matrizes`. It drives that memory's single read/write port directly: it reads operands from A (id 00) and B (id 01) and writes results into C (id 10). One start pulse runs a full operation; a done pulse reports completion. It sits between the host/command logic and the matrix memory.

## Interface
- `DIM`, 5: matrix dimension. Must equal the memory's 5x5 organisation.
- `WIDTH`, 16: element width, signed two's complement.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: begin an operation. Sampled only in IDLE.
- `op` input 2: 00 add, 01 subtract (A−B), 10 matrix product (A×B), 11 invalid. Sampled with `start`.
- `busy` output 1: high while an operation is in progress.
- `done` output 1: one-cycle completion pulse.
- `erro` output 1: valid with `done`; 1 means op 11 was rejected.
- `overflow` output 1: sticky; set if any result exceeded the signed WIDTH range. Cleared on accepted `start`.
- `mem_we` output 1: memory write enable.
- `mem_re` output 1: memory read enable.
- `mem_id` output 2: matrix select.
- `mem_linha` output 3: row index.
- `mem_coluna` output 3: column index.
- `mem_dado_w` output WIDTH: write data.
- `mem_dado_r` input WIDTH: memory read data. Valid the cycle after `mem_re`.

## Operation
- All outputs are registered. Reset value of every output is 0. Reset also forces state IDLE and clears the counters, operand register and accumulator.
- States:
  - IDLE: waits for `start`.
  - RD_A
  - RD_B
  - CALC
  - WR
  - FIM
- IDLE transitions on `start`:
  - Op 00, 01 or 10: latch op, clear i/j/k and `overflow`, go to RD_A.
  - Op 11: go to FIM with `erro` set. No memory access occurs.
- RD_A: drive `mem_re`=1, `mem_id`=00.
  - Add/sub: address (i,j).
  - Product: address (i,k).
- RD_B: drive `mem_re`=1, `mem_id`=01.
  - Add/sub: address (i,j).
  - Product: address (k,j).
  - Capture `mem_dado_r` (the A element) into `reg_a`.
- CALC: `mem_dado_r` now holds the B element.
  - Add/sub: `res` = `reg_a` ± B, computed in WIDTH+1 bits.
  - Product: `acc` += `reg_a`*B, with a 2*WIDTH+3 bit signed accumulator cleared at k=0. If k<DIM−1, increment k and return to RD_A; otherwise go to WR.
- WR: drive `mem_we`=1, `mem_id`=10, address (i,j), `mem_dado_w` = the narrowed result (see Configuration).
  - Advance j; wrap j at DIM−1 to 0 and increment i.
  - After (4,4), go to FIM; otherwise go to RD_A.
- FIM: `done`=1 for one cycle, then IDLE.
- Traversal order is row-major: i outer, j inner.
- `start` while busy is ignored. `op` changes during an operation are ignored.
- `overflow` is set in WR when the full-width result lies outside [−2^(WIDTH−1), 2^(WIDTH−1)−1].
- Reset mid-operation aborts immediately. C contents are then partially written and unspecified; no `done` is produced.

## Timing
- `start` is sampled at edge E0; `busy` rises after E0.
- Add/sub: 4 cycles per element, 100 busy cycles. `done` is high in cycle 101 after E0, and `busy` is low in that cycle.
- Product: 3 cycles per k-step plus 1 WR cycle, so 16 cycles per element and 400 busy cycles. `done` is in cycle 401.
- Op 11: `done`=1 and `erro`=1 in the cycle after E0. `busy` never rises.
- `mem_re` and `mem_we` are never high in the same cycle. The first WR to C(i,j) occurs only after all reads for C(i,j), so A or B may not alias C.
- A new `start` is accepted in the cycle after FIM, i.e. the first IDLE cycle.

## Configuration
- `SATURACAO_EN` defined: out-of-range results clamp to 16'h7FFF (positive) or 16'h8000 (negative) before the write.
- `SATURACAO_EN` undefined: the write takes the low WIDTH bits (wrap-around).
- `overflow` behaves identically in both builds.

## Structure
- Shared package `pacote_matrizes` holds:
  - op encodings OP_SOMA, OP_SUB, OP_MUL, OP_INV;
  - matrix ids ID_A=00, ID_B=01, ID_C=10;
  - DIM;
  - the state enum.
- Sub-module `unidade_mac` holds the combinational add/sub/multiply-accumulate, overflow detection and the `SATURACAO_EN` narrowing. The FSM and counters stay in the top.

## Test plan
- Preload A(i,j)=i*5+j and B all 2, then op 00 → C(i,j)=i*5+j+2. `done` in cycle 101, `overflow`=0, exactly 25 writes.
- A=identity, B(i,j)=i−j, op 10 → C=B. `done` in cycle 401.
- A all 16'h7000, B all 16'h7000, op 00 → `overflow`=1. C = 16'h7FFF with `SATURACAO_EN`, 16'hE000 without.
- Op 11 → `done`=`erro`=1 next cycle, `mem_re`/`mem_we` never asserted. A following op 01 with A=B → C all 0, `erro`=0.
- Pulse `start` again at cycle 50 of an add → ignored; single `done` at cycle 101.
- Assert `rst_n`=0 at cycle 200 of a product → all outputs 0 immediately. A following op 00 completes normally.
